// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU bridge: default widths and the
// frame-sequencing state encoding.
package uart_alu_pkg;

    localparam int N_BITS_DEF = 8;
    localparam int N_OP_DEF   = 6;

    // Frame sequencing: three received bytes (A, B, opcode), one compute
    // cycle, one transmit request, then wait for the transmitter to finish.
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    // True in the states where a received byte is part of the frame
    // rather than an overrun.
    function automatic logic is_rx_accept_state(input state_t s);
        return (s == WAIT_A) || (s == WAIT_B) || (s == WAIT_OP);
    endfunction

endpackage

// File: rtl/uart_alu_if_timer.sv
// Inter-byte timeout counter for the UART-to-ALU bridge. Only instantiated
// when UART_ALU_IF_TIMEOUT_EN is defined.
module uart_alu_if_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_count_en,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Restart on every accepted byte or whenever the frame is not mid-way;
    // hold at the terminal value so it can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || !i_count_en) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_count_en && (cnt_q == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// UART-to-ALU bridge: collects operand A, operand B and an opcode byte from
// a UART receiver, presents them to an external combinational ALU, and hands
// the result to a UART transmitter. Bytes arriving while a result is in
// flight are dropped and flagged on o_overrun.
// Optional inter-byte timeout is compiled in with macro UART_ALU_IF_TIMEOUT_EN;
// without it o_timeout is tied low and the bridge waits indefinitely.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int N_BITS         = N_BITS_DEF,
    parameter int N_OP           = N_OP_DEF,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_rx_done_tick,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic [N_BITS-1:0] i_alu_result,
    input  logic              i_tx_done_tick,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [N_OP-1:0]   o_alu_op,
    output logic              o_tx_start,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_overrun,
    output logic              o_timeout
);

    state_t            state_q;
    logic [N_BITS-1:0] a_shadow_q;
    logic [N_BITS-1:0] b_shadow_q;
    logic [N_BITS-1:0] alu_a_q;
    logic [N_BITS-1:0] alu_b_q;
    logic [N_OP-1:0]   alu_op_q;
    logic [N_BITS-1:0] tx_data_q;
    logic              tx_start_q;
    logic              overrun_q;

`ifdef UART_ALU_IF_TIMEOUT_EN
    logic timeout_q;
    logic timer_en;
    logic timer_clear;
    logic timer_expired;

    assign timer_en    = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timer_clear = i_rx_done_tick && is_rx_accept_state(state_q);

    uart_alu_if_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_count_en(timer_en),
        .i_clear   (timer_clear),
        .o_expired (timer_expired)
    );

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    // Frame sequencer with registered outputs. The ALU operand registers are
    // only loaded on the opcode byte so the ALU sees a stable input set while
    // the next frame's operands collect in the shadow registers. Pulses
    // default low every cycle so each lasts exactly one clock.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q    <= WAIT_A;
            a_shadow_q <= '0;
            b_shadow_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_ALU_IF_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_ALU_IF_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                WAIT_A: begin
                    if (i_rx_done_tick) begin
                        a_shadow_q <= i_rx_data;
                        state_q    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done_tick) begin
                        b_shadow_q <= i_rx_data;
                        state_q    <= WAIT_OP;
                    end
`ifdef UART_ALU_IF_TIMEOUT_EN
                    else if (timer_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= WAIT_A;
                    end
`endif
                end
                WAIT_OP: begin
                    if (i_rx_done_tick) begin
                        alu_a_q  <= a_shadow_q;
                        alu_b_q  <= b_shadow_q;
                        alu_op_q <= i_rx_data[N_OP-1:0];
                        state_q  <= EXEC;
                    end
`ifdef UART_ALU_IF_TIMEOUT_EN
                    else if (timer_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= WAIT_A;
                    end
`endif
                end
                EXEC: begin
                    tx_data_q <= i_alu_result;
                    overrun_q <= i_rx_done_tick;
                    state_q   <= SEND;
                end
                SEND: begin
                    tx_start_q <= 1'b1;
                    overrun_q  <= i_rx_done_tick;
                    state_q    <= WAIT_TX;
                end
                WAIT_TX: begin
                    overrun_q <= i_rx_done_tick;
                    if (i_tx_done_tick) begin
                        state_q <= WAIT_A;
                    end
                end
                default: begin
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface. Expected results are queued
// when a frame's bytes are driven and checked when o_tx_start fires.
// Timeout behaviour depends on whether UART_ALU_IF_TIMEOUT_EN is defined.
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       overrun;
    logic       timeout;

    int         testsRun = 0;
    int         testsFailed = 0;
    int         txStartCount = 0;
    int         timeoutCount = 0;
    logic [7:0] expQ[$];

    uart_alu_interface #(
        .N_BITS(8),
        .N_OP(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (reset_n),
        .i_rx_done_tick(rx_tick),
        .i_rx_data     (rx_data),
        .i_alu_result  (alu_result),
        .i_tx_done_tick(tx_done),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_op      (alu_op),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .o_overrun     (overrun),
        .o_timeout     (timeout)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // External combinational ALU stub driven by the DUT's operand outputs
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    // Reference ALU computed from the bytes as sent
    function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] op);
        case (op[5:0])
            6'h20:   return a + b;
            6'h22:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every transmit request pops and checks one expected result
    always @(negedge clk) begin
        if (reset_n && tx_start) begin
            txStartCount++;
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_tx", expQ.size(), 1);
            end else begin
                checkOutput("sb_tx_data", tx_data, expQ.pop_front());
            end
        end
        if (timeout) timeoutCount++;
    end

    // One received byte: rx_tick high for exactly one sampling edge
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_tick = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_tick = 1'b0;
    endtask

    task automatic pulseTxDone();
        @(posedge clk);
        #1;
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
    endtask

    // Called right after the opcode byte was sampled: checks operands and
    // that o_tx_start rises exactly 2 clocks after that sampling edge
    task automatic checkFrameTail(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] op);
        int startBefore;
        startBefore = txStartCount;
        @(negedge clk);
        checkOutput("exec_no_start", tx_start, 0);
        checkOutput("alu_a", alu_a, a);
        checkOutput("alu_b", alu_b, b);
        checkOutput("alu_op", alu_op, op[5:0]);
        @(negedge clk);
        checkOutput("send_no_start", tx_start, 0);
        @(negedge clk);
        checkOutput("start_pulse", tx_start, 1);
        checkOutput("tx_data", tx_data, aluModel(a, b, op));
        @(negedge clk);
        checkOutput("start_single", tx_start, 0);
        checkOutput("start_count", txStartCount - startBefore, 1);
    endtask

    task automatic runFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        expQ.push_back(aluModel(a, b, op));
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(op);
        checkFrameTail(a, b, op);
    endtask

    initial begin
        int startBefore;
        int toBefore;
        int firstAt;
        int pulses;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_pulses", {tx_start, overrun, timeout}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic ADD, then wrap, then SUB
        runFrame(8'h05, 8'h03, 8'h20);
        pulseTxDone();
        runFrame(8'hFF, 8'h01, 8'h20);
        pulseTxDone();
        runFrame(8'h0A, 8'h04, 8'h22);

        // Byte during WAIT_TX is dropped and flagged
        applyStimulus(8'h55);
        @(negedge clk);
        checkOutput("overrun_pulse", overrun, 1);
        checkOutput("overrun_tx_hold", tx_data, 8'h06);
        @(negedge clk);
        checkOutput("overrun_single", overrun, 0);
        pulseTxDone();
        pulseTxDone();
        runFrame(8'h11, 8'h22, 8'h24);
        pulseTxDone();

        // Reset mid-frame discards the partial frame
        applyStimulus(8'h40);
        applyStimulus(8'h41);
        startBefore = txStartCount;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_alu_a", alu_a, 0);
        checkOutput("midrst_alu_b", alu_b, 0);
        checkOutput("midrst_alu_op", alu_op, 0);
        checkOutput("midrst_tx_data", tx_data, 0);
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_start", txStartCount, startBefore);
        runFrame(8'h30, 8'h0C, 8'h22);
        pulseTxDone();

`ifdef UART_ALU_IF_TIMEOUT_EN
        // Silence after byte A aborts the frame 16 clocks later
        applyStimulus(8'h07);
        firstAt = -1;
        pulses = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (timeout) begin
                pulses++;
                if (firstAt < 0) firstAt = j;
            end
        end
        checkOutput("timeout_pulses", pulses, 1);
        checkOutput("timeout_delay", firstAt, 16);
        runFrame(8'h01, 8'h02, 8'h20);
        pulseTxDone();

        // Byte arriving on the terminal count is accepted, no timeout
        toBefore = timeoutCount;
        expQ.push_back(aluModel(8'h07, 8'h02, 8'h20));
        applyStimulus(8'h07);
        repeat (14) @(posedge clk);
        applyStimulus(8'h02);
        applyStimulus(8'h20);
        checkFrameTail(8'h07, 8'h02, 8'h20);
        checkOutput("timeout_boundary", timeoutCount, toBefore);
        pulseTxDone();
`else
        // Without the timeout feature the bridge waits indefinitely
        toBefore = timeoutCount;
        startBefore = txStartCount;
        expQ.push_back(aluModel(8'h07, 8'h02, 8'h20));
        applyStimulus(8'h07);
        repeat (40) @(negedge clk);
        checkOutput("no_timeout", timeoutCount, toBefore);
        checkOutput("no_start_idle", txStartCount, startBefore);
        applyStimulus(8'h02);
        applyStimulus(8'h20);
        checkFrameTail(8'h07, 8'h02, 8'h20);
        pulseTxDone();
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 SHALL have parameter N_BITS, default 8: data byte, operand and result width.
REQ-002 SHALL have parameter N_OP, default 6: opcode width, taken from the low bits of the op byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: inter-byte timeout in clocks, used only when the timeout feature is compiled in.
REQ-004 SHALL have port i_clock  in  1: the single clock; all logic rising-edge.
REQ-005 SHALL have port i_reset_n  in  1: synchronous, active-low reset.
REQ-006 SHALL have port i_rx_done_tick  in  1: one-cycle strobe from the UART receiver; received byte valid.
REQ-007 SHALL have port i_rx_data  in  N_BITS: received byte, sampled only when i_rx_done_tick=1.
REQ-008 SHALL have port i_alu_result  in  N_BITS: combinational ALU result computed from o_alu_a, o_alu_b and o_alu_op.
REQ-009 SHALL have port i_tx_done_tick  in  1: one-cycle strobe from the UART transmitter; byte sent.
REQ-010 SHALL have ports o_alu_a and o_alu_b  out  N_BITS each: ALU operands.
REQ-011 SHALL have port o_alu_op  out  N_OP: ALU opcode.
REQ-012 SHALL have port o_tx_start  out  1: one-cycle request to the transmitter.
REQ-013 SHALL have port o_tx_data  out  N_BITS: byte to transmit.
REQ-014 SHALL have port o_overrun  out  1: one-cycle pulse when a received byte is dropped.
REQ-015 SHALL have port o_timeout  out  1: one-cycle pulse when a partial frame is aborted by timeout.

Function
REQ-016 SHALL implement states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX.
REQ-017 SHALL transition from WAIT_A to WAIT_B on i_rx_done_tick, capturing i_rx_data into the A shadow register.
REQ-018 SHALL transition from WAIT_B to WAIT_OP on i_rx_done_tick, capturing i_rx_data into the B shadow register.
REQ-019 SHALL transition from WAIT_OP to EXEC on i_rx_done_tick, loading o_alu_a and o_alu_b from the shadow registers and o_alu_op from i_rx_data[N_OP-1:0] in the same edge.
REQ-020 SHALL hold o_alu_a, o_alu_b and o_alu_op constant between EXEC entries; shadow captures SHALL NOT alter them.
REQ-021 SHALL, in EXEC (one cycle), register i_alu_result into o_tx_data and then enter SEND.
REQ-022 SHALL, in SEND (one cycle), assert o_tx_start=1 and then enter WAIT_TX.
REQ-023 SHALL assert o_tx_start only in the SEND state, giving exactly one pulse per frame.
REQ-024 SHALL place o_tx_start exactly 2 clocks after the edge that sampled the op byte's i_rx_done_tick.
REQ-025 SHALL transition from WAIT_TX to WAIT_A on i_tx_done_tick.
REQ-026 SHALL hold o_tx_data stable from EXEC exit until the next EXEC.
REQ-027 SHALL drop any i_rx_done_tick arriving in EXEC, SEND or WAIT_TX (including the cycle i_tx_done_tick arrives) and pulse o_overrun=1 for one cycle, with no state change.
REQ-028 SHALL ignore i_tx_done_tick outside WAIT_TX.
REQ-029 SHALL treat any illegal state encoding as WAIT_A on the next clock, with no output pulse.

Reset
REQ-030 SHALL, while i_reset_n=0 at a clock edge, set state to WAIT_A.
REQ-031 SHALL, while i_reset_n=0 at a clock edge, clear shadow registers, o_alu_a, o_alu_b, o_alu_op and o_tx_data to 0, and o_tx_start, o_overrun and o_timeout to 0.
REQ-032 SHALL, on reset at any point in a frame, discard the partial frame and issue no o_tx_start.

Configuration
REQ-033 SHALL provide a timeout feature controlled by macro UART_ALU_IF_TIMEOUT_EN.
REQ-034 SHALL, when UART_ALU_IF_TIMEOUT_EN is defined, clear a counter on every accepted byte and increment it each clock in WAIT_B or WAIT_OP.
REQ-035 SHALL, when UART_ALU_IF_TIMEOUT_EN is defined and the counter reaches TIMEOUT_CYCLES-1 without a byte, return to WAIT_A and pulse o_timeout=1 for one cycle.
REQ-036 SHALL, when UART_ALU_IF_TIMEOUT_EN is defined and a byte arrives on the same cycle the counter reaches TIMEOUT_CYCLES-1, accept the byte and not time out.
REQ-037 SHALL, when UART_ALU_IF_TIMEOUT_EN is undefined, build no counter, tie o_timeout to 0, and wait indefinitely.

Structure
REQ-038 SHALL take state encoding constants and default N_BITS/N_OP values from shared package uart_alu_pkg.
REQ-039 SHALL implement the timeout counter as sub-module uart_alu_if_timer, instantiated only when UART_ALU_IF_TIMEOUT_EN is defined; all other logic SHALL be inline.

Verification
REQ-040 SHALL cover: bytes 0x05, 0x03, 0x20 with ALU model ADD -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_data=0x08, a single o_tx_start pulse 2 clocks after the third tick.
REQ-041 SHALL cover: bytes 0xFF, 0x01, 0x20 -> o_tx_data=0x00 (wrap); then i_tx_done_tick -> WAIT_A, and a second frame 0x0A, 0x04, 0x22 (SUB) -> o_tx_data=0x06.
REQ-042 SHALL cover: a byte 0x55 received during WAIT_TX -> one o_overrun pulse, o_tx_data unchanged, next frame unaffected.
REQ-043 SHALL cover: i_reset_n=0 for 1 clock after the A and B bytes -> all outputs 0, no o_tx_start; a following full frame works normally.
REQ-044 SHALL cover: with the macro defined and TIMEOUT_CYCLES=16, byte 0x07 then silence -> o_timeout pulse 16 clocks later, state WAIT_A; the next three bytes form a fresh frame.
REQ-045 SHALL cover: with the macro undefined, the same 0x07-then-silence stimulus -> no pulse, and the frame completes when the remaining bytes arrive.
